lsu_bus_master: RTL and testbench

- Load/store initiator for the MEM stage of the pipelined RISC-V core.
- Converts a load or store from the pipeline into one word-aligned transaction on a valid/ready data bus, carrying byte enables.
- Stalls the pipeline until the bus responds, then returns the load data already extracted and sign- or zero-extended.
- Pairs with a handshaked data-memory responder. It replaces direct combinational access to the data array.

---
 rtl/lsu_pkg.sv | 46 ++++
 rtl/lsu_bus_master_align.sv | 61 ++++++
 rtl/lsu_bus_master.sv | 171 +++++++++++++++++
 tb/tb_lsu_bus_master.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store bus master: access-size codes,
// FSM state encoding and request-classification helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RSP  = 2'b10,
        DONE = 2'b11
    } lsu_state_e;

    // Width of the response-timeout counter; never below one bit so a
    // disabled timeout (0) still yields a legal vector.
    function automatic int cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

    // Unsigned sizes exist only for loads.
    function automatic logic f3_is_legal(input logic [2:0] f3, input logic is_store);
        logic legal;
        case (f3)
            F3_B, F3_H, F3_W: legal = 1'b1;
            F3_BU, F3_HU:     legal = ~is_store;
            default:          legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        case (f3)
            F3_H, F3_HU: mis = off[0];
            F3_W:        mis = (off != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_bus_master_align.sv
// Byte-lane logic: store data replication and byte enables on the way out,
// byte/halfword extraction and sign/zero extension on the way back.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_off,
    input  logic        st_we,
    input  logic [31:0] st_wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_rdata,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_data
);

    logic [15:0] shifted_s;

    // Move the addressed byte/halfword down to bit 0 before extension.
    assign shifted_s = 16'(ld_rdata >> {ld_off, 3'b000});

    // Store lane steering; reads always fetch the whole word.
    always_comb begin
        be         = 4'b1111;
        lane_wdata = st_wdata;
        if (st_we) begin
            case (st_funct3)
                F3_B: begin
                    be         = 4'b0001 << st_off;
                    lane_wdata = {4{st_wdata[7:0]}};
                end
                F3_H: begin
                    be         = st_off[1] ? 4'b1100 : 4'b0011;
                    lane_wdata = {2{st_wdata[15:0]}};
                end
                default: begin
                    be         = 4'b1111;
                    lane_wdata = st_wdata;
                end
            endcase
        end else begin
            be         = 4'b1111;
            lane_wdata = st_wdata;
        end
    end

    // Load extraction with sign or zero extension by access type.
    always_comb begin
        load_data = 32'h0000_0000;
        case (ld_funct3)
            F3_B:    load_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
            F3_BU:   load_data = {24'h00_0000, shifted_s[7:0]};
            F3_H:    load_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
            F3_HU:   load_data = {16'h0000, shifted_s[15:0]};
            F3_W:    load_data = ld_rdata;
            default: load_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu_bus_master.sv
// MEM-stage load/store initiator: turns one pipeline access into a single
// word-aligned valid/ready bus transaction and stalls until it completes.
module lsu_bus_master
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_rd_en,
    input  logic              mem_wr_en,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall_o,
    output logic [31:0]       load_data_o,
    output logic              done_o,
    output logic              misalign_o,
    output logic              err_o,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic              bus_req_we,
    output logic [ADDR_W-1:0] bus_req_addr,
    output logic [31:0]       bus_req_wdata,
    output logic [3:0]        bus_req_be,
    input  logic              bus_rsp_valid,
    input  logic [31:0]       bus_rsp_rdata
);

    localparam int CNT_W = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? {CNT_W{1'b0}} : CNT_W'(TIMEOUT - 1);

    lsu_state_e        state_r, state_s;
    logic              we_r;
    logic [ADDR_W-3:0] waddr_r;
    logic [3:0]        be_r;
    logic [31:0]       wdata_r;
    logic [2:0]        f3_r;
    logic [1:0]        off_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [31:0]       load_data_r;
    logic              to_err_r;

    logic              req_s, illegal_s, misalign_s, launch_s, timeout_s;
    logic [3:0]        be_s;
    logic [31:0]       lane_wdata_s, load_ext_s;

    assign req_s      = mem_rd_en | mem_wr_en;
    assign illegal_s  = (mem_rd_en & mem_wr_en) | ~f3_is_legal(funct3, mem_wr_en);
    assign misalign_s = is_misaligned(funct3, addr[1:0]);

    lsu_align u_align (
        .st_funct3  (funct3),
        .st_off     (addr[1:0]),
        .st_we      (mem_wr_en),
        .st_wdata   (wdata),
        .ld_funct3  (f3_r),
        .ld_off     (off_r),
        .ld_rdata   (bus_rsp_rdata),
        .be         (be_s),
        .lane_wdata (lane_wdata_s),
        .load_data  (load_ext_s)
    );

    // Next-state decode plus the stall and single-cycle status pulses.
    always_comb begin
        state_s    = state_r;
        stall_o    = 1'b0;
        misalign_o = 1'b0;
        err_o      = 1'b0;
        launch_s   = 1'b0;
        timeout_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    if (illegal_s) begin
                        err_o = 1'b1;
                    end else if (misalign_s) begin
                        misalign_o = 1'b1;
                    end else begin
                        launch_s = 1'b1;
                        stall_o  = 1'b1;
                        state_s  = REQ;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                stall_o = 1'b1;
                if (bus_req_ready) begin
                    state_s = RSP;
                end else begin
                    state_s = REQ;
                end
            end
            RSP: begin
                stall_o = 1'b1;
                if (bus_rsp_valid) begin
                    state_s = DONE;
                end else if ((TIMEOUT != 0) && (cnt_r == TO_LAST)) begin
                    timeout_s = 1'b1;
                    state_s   = DONE;
                end else begin
                    state_s = RSP;
                end
            end
            DONE: begin
                err_o   = to_err_r;
                state_s = IDLE;
            end
            default: state_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_r <= IDLE;
        else      state_r <= state_s;
    end

    // Capture the request at launch so the bus sees stable fields in REQ.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_r    <= 1'b0;
            waddr_r <= {(ADDR_W-2){1'b0}};
            be_r    <= 4'b0000;
            wdata_r <= 32'h0000_0000;
            f3_r    <= 3'b000;
            off_r   <= 2'b00;
        end else if (launch_s) begin
            we_r    <= mem_wr_en;
            waddr_r <= addr[ADDR_W-1:2];
            be_r    <= be_s;
            wdata_r <= lane_wdata_s;
            f3_r    <= funct3;
            off_r   <= addr[1:0];
        end
    end

    // Response-wait counter: cleared while requesting, counts RSP cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                  cnt_r <= {CNT_W{1'b0}};
        else if (state_r == REQ)   cnt_r <= {CNT_W{1'b0}};
        else if (state_r == RSP)   cnt_r <= cnt_r + CNT_W'(1);
    end

    // Completion result: extended load data, zero for stores and timeouts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_data_r <= 32'h0000_0000;
            to_err_r    <= 1'b0;
        end else if ((state_r == RSP) && bus_rsp_valid) begin
            load_data_r <= we_r ? 32'h0000_0000 : load_ext_s;
            to_err_r    <= 1'b0;
        end else if (timeout_s) begin
            load_data_r <= 32'h0000_0000;
            to_err_r    <= 1'b1;
        end
    end

    assign load_data_o   = load_data_r;
    assign done_o        = (state_r == DONE) & ~to_err_r;
    assign bus_req_valid = (state_r == REQ);
    assign bus_req_we    = we_r;
    assign bus_req_addr  = {waddr_r, 2'b00};
    assign bus_req_wdata = wdata_r;
    assign bus_req_be    = be_r;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Self-checking bench for lsu_bus_master: directed scenarios plus random
// accesses against a byte-array reference model of the bus behaviour.
module tb_lsu_bus_master;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_rd_en = 1'b0, mem_wr_en = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic        stall_o, done_o, misalign_o, err_o;
    logic [31:0] load_data_o;
    logic        bus_req_valid, bus_req_we;
    logic        bus_req_ready = 1'b0;
    logic [31:0] bus_req_addr, bus_req_wdata;
    logic [3:0]  bus_req_be;
    logic        bus_rsp_valid = 1'b0;
    logic [31:0] bus_rsp_rdata = 32'h0;

    int vectors = 0;
    int miscompares = 0;

    // Observations recorded by run_access
    int          stall_cnt, done_cnt, err_cnt, req_cyc, rsp_cyc;
    logic        end_stall, stable_bad, req_seen, finished;
    logic [31:0] obs_addr, obs_wdata;
    logic [3:0]  obs_be;
    logic        obs_we;

    always #5 clk = ~clk;

    lsu_bus_master #(.TIMEOUT(TO), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .funct3(funct3), .addr(addr), .wdata(wdata), .stall_o(stall_o),
        .load_data_o(load_data_o), .done_o(done_o), .misalign_o(misalign_o),
        .err_o(err_o), .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_req_we(bus_req_we), .bus_req_addr(bus_req_addr),
        .bus_req_wdata(bus_req_wdata), .bus_req_be(bus_req_be),
        .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata)
    );

    function automatic int acc_size(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
    endfunction

    // Reference load: gather n bytes little-endian from offset, extend.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] rd);
        logic [7:0]  bytes [4];
        logic [31:0] v;
        int n;
        for (int i = 0; i < 4; i++) bytes[i] = rd[i*8 +: 8];
        n = acc_size(f3);
        v = 32'h0;
        for (int i = n - 1; i >= 0; i--) v = (v << 8) | {24'h0, bytes[int'(off) + i]};
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    function automatic logic [3:0] ref_be(input logic is_store, input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] b;
        if (!is_store) return 4'hF;
        b = 4'h0;
        for (int i = 0; i < acc_size(f3); i++) b[int'(off) + i] = 1'b1;
        return b;
    endfunction

    function automatic logic [31:0] ref_lane(input logic [2:0] f3, input logic [31:0] wd);
        int n;
        logic [31:0] mask, v;
        n = acc_size(f3);
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*n)) - 32'h1);
        v = 32'h0;
        for (int k = 0; k < 4 / n; k++) v = v | ((wd & mask) << (8*n*k));
        return v;
    endfunction

    // Drive one access and act as the responder; records what the DUT did.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                              input int rdy_wait, input int rsp_wait, input logic inject);
        int phase, rq, rs;
        logic acc, rsp_t;
        stall_cnt = 0; done_cnt = 0; err_cnt = 0; req_cyc = 0; rsp_cyc = 0;
        stable_bad = 1'b0; req_seen = 1'b0; finished = 1'b0; end_stall = 1'b1;
        mem_rd_en = rd; mem_wr_en = wr; funct3 = f3; addr = a; wdata = wd;
        @(negedge clk);
        if (stall_o) stall_cnt++;
        @(posedge clk); #1;
        mem_rd_en = 1'b0; mem_wr_en = 1'b0;
        phase = 0; rq = 0; rs = 0;
        for (int c = 0; c < 64 && !finished; c++) begin
            bus_req_ready = (phase == 0) && (rq >= rdy_wait);
            bus_rsp_valid = ((phase == 1) && (rs >= rsp_wait)) || ((phase == 0) && inject && (rq < rdy_wait));
            bus_rsp_rdata = (phase == 1) ? rdat : 32'hDEAD_BEEF;
            @(negedge clk);
            if (done_o || err_o) begin
                finished = 1'b1;
                end_stall = stall_o;
                if (done_o) done_cnt++;
                if (err_o) err_cnt++;
            end else begin
                if (stall_o) stall_cnt++;
                if (bus_req_valid) begin
                    if (!req_seen) begin
                        obs_addr = bus_req_addr; obs_be = bus_req_be;
                        obs_wdata = bus_req_wdata; obs_we = bus_req_we; req_seen = 1'b1;
                    end else if (obs_addr !== bus_req_addr || obs_be !== bus_req_be ||
                                 obs_wdata !== bus_req_wdata || obs_we !== bus_req_we) begin
                        stable_bad = 1'b1;
                    end
                    req_cyc++;
                end
            end
            acc = bus_req_valid && bus_req_ready;
            rsp_t = (phase == 1) && bus_rsp_valid;
            @(posedge clk); #1;
            if (!finished) begin
                if (phase == 0) begin
                    if (acc) phase = 1; else rq++;
                end else if (phase == 1) begin
                    rsp_cyc++;
                    if (rsp_t) phase = 2; else rs++;
                end
            end
        end
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        vectors++; if (stall_o !== 1'b0) begin miscompares++; $display("FAIL reset_stall got %b want 0", stall_o); end
        vectors++; if (bus_req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", bus_req_valid); end
        vectors++; if (load_data_o !== 32'h0) begin miscompares++; $display("FAIL reset_load got %h want 0", load_data_o); end
        vectors++; if ({done_o, misalign_o, err_o} !== 3'b000) begin miscompares++; $display("FAIL reset_pulses got %b want 000", {done_o, misalign_o, err_o}); end
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_store_word();
        run_access(1'b0, 1'b1, 3'b010, 32'h10, 32'hCAFE_BABE, 32'h0, 0, 0, 1'b0);
        vectors++; if (finished !== 1'b1) begin miscompares++; $display("FAIL sw_complete got %b want 1", finished); end
        vectors++; if (obs_addr !== 32'h10) begin miscompares++; $display("FAIL sw_addr got %h want 10", obs_addr); end
        vectors++; if (obs_be !== 4'hF) begin miscompares++; $display("FAIL sw_be got %h want f", obs_be); end
        vectors++; if (obs_we !== 1'b1) begin miscompares++; $display("FAIL sw_we got %b want 1", obs_we); end
        vectors++; if (obs_wdata !== 32'hCAFE_BABE) begin miscompares++; $display("FAIL sw_wdata got %h want cafebabe", obs_wdata); end
        vectors++; if (stall_cnt !== 3) begin miscompares++; $display("FAIL sw_stall_cycles got %0d want 3", stall_cnt); end
        vectors++; if (done_cnt !== 1 || end_stall !== 1'b0) begin miscompares++; $display("FAIL sw_done got done=%0d stall=%b want 1/0", done_cnt, end_stall); end
    endtask

    task automatic test_loads();
        run_access(1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 32'h8011_2233, 0, 0, 1'b0);
        vectors++; if (load_data_o !== 32'hFFFF_FF80) begin miscompares++; $display("FAIL lb13 got %h want ffffff80", load_data_o); end
        vectors++; if (obs_be !== 4'hF || obs_we !== 1'b0 || obs_addr !== 32'h10) begin miscompares++; $display("FAIL lb13_req got be=%h we=%b a=%h want f/0/10", obs_be, obs_we, obs_addr); end
        run_access(1'b1, 1'b0, 3'b100, 32'h13, 32'h0, 32'h8011_2233, 0, 0, 1'b0);
        vectors++; if (load_data_o !== 32'h0000_0080) begin miscompares++; $display("FAIL lbu13 got %h want 00000080", load_data_o); end
        run_access(1'b1, 1'b0, 3'b000, 32'h11, 32'h0, 32'h8011_2233, 0, 0, 1'b0);
        vectors++; if (load_data_o !== 32'h0000_0022) begin miscompares++; $display("FAIL lb11 got %h want 00000022", load_data_o); end
        run_access(1'b1, 1'b0, 3'b001, 32'h12, 32'h0, 32'h8001_5555, 0, 0, 1'b0);
        vectors++; if (load_data_o !== 32'hFFFF_8001) begin miscompares++; $display("FAIL lh12 got %h want ffff8001", load_data_o); end
    endtask

    task automatic test_store_half();
        run_access(1'b0, 1'b1, 3'b001, 32'h12, 32'h1234_ABCD, 32'h0, 0, 0, 1'b0);
        vectors++; if (obs_addr !== 32'h10) begin miscompares++; $display("FAIL sh_addr got %h want 10", obs_addr); end
        vectors++; if (obs_be !== 4'b1100) begin miscompares++; $display("FAIL sh_be got %b want 1100", obs_be); end
        vectors++; if (obs_wdata !== 32'hABCD_ABCD) begin miscompares++; $display("FAIL sh_wdata got %h want abcdabcd", obs_wdata); end
        vectors++; if (load_data_o !== 32'h0) begin miscompares++; $display("FAIL sh_load got %h want 0", load_data_o); end
    endtask

    task automatic test_misalign();
        logic        rd_t  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic        wr_t  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [2:0]  f3_t  [6] = '{3'b010, 3'b001, 3'b010, 3'b010, 3'b011, 3'b100};
        logic [31:0] a_t   [6] = '{32'h06, 32'h11, 32'h02, 32'h10, 32'h20, 32'h20};
        logic        mis_t [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            mem_rd_en = rd_t[i]; mem_wr_en = wr_t[i]; funct3 = f3_t[i]; addr = a_t[i]; wdata = 32'h5A5A_5A5A;
            @(negedge clk);
            vectors++; if (misalign_o !== mis_t[i]) begin miscompares++; $display("FAIL reject%0d_misalign got %b want %b", i, misalign_o, mis_t[i]); end
            vectors++; if (err_o !== !mis_t[i]) begin miscompares++; $display("FAIL reject%0d_err got %b want %b", i, err_o, !mis_t[i]); end
            vectors++; if (stall_o !== 1'b0) begin miscompares++; $display("FAIL reject%0d_stall got %b want 0", i, stall_o); end
            @(posedge clk); #1;
            mem_rd_en = 1'b0; mem_wr_en = 1'b0;
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                vectors++; if ({bus_req_valid, stall_o, misalign_o, err_o} !== 4'b0000) begin miscompares++; $display("FAIL reject%0d_quiet got %b want 0000", i, {bus_req_valid, stall_o, misalign_o, err_o}); end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_backpressure();
        run_access(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 32'h1357_9BDF, 3, 0, 1'b1);
        vectors++; if (req_cyc !== 4) begin miscompares++; $display("FAIL bp_valid_cycles got %0d want 4", req_cyc); end
        vectors++; if (stable_bad !== 1'b0) begin miscompares++; $display("FAIL bp_lw_stable got %b want 0", stable_bad); end
        vectors++; if (load_data_o !== 32'h1357_9BDF) begin miscompares++; $display("FAIL bp_lw_data got %h want 13579bdf", load_data_o); end
        vectors++; if (stall_cnt !== 6) begin miscompares++; $display("FAIL bp_stall got %0d want 6", stall_cnt); end
        run_access(1'b0, 1'b1, 3'b000, 32'h23, 32'h0000_00A5, 32'h0, 3, 1, 1'b0);
        vectors++; if (stable_bad !== 1'b0 || req_cyc !== 4) begin miscompares++; $display("FAIL bp_sb_stable got bad=%b cyc=%0d want 0/4", stable_bad, req_cyc); end
        vectors++; if (obs_be !== 4'b1000 || obs_wdata !== 32'hA5A5_A5A5) begin miscompares++; $display("FAIL bp_sb_lanes got be=%b wd=%h want 1000/a5a5a5a5", obs_be, obs_wdata); end
    endtask

    task automatic test_timeout();
        run_access(1'b1, 1'b0, 3'b010, 32'h44, 32'h0, 32'h55AA_55AA, 0, 0, 1'b0);
        vectors++; if (load_data_o !== 32'h55AA_55AA) begin miscompares++; $display("FAIL to_preload got %h want 55aa55aa", load_data_o); end
        run_access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 0, 1000, 1'b0);
        vectors++; if (finished !== 1'b1 || err_cnt !== 1) begin miscompares++; $display("FAIL to_err got fin=%b err=%0d want 1/1", finished, err_cnt); end
        vectors++; if (done_cnt !== 0) begin miscompares++; $display("FAIL to_no_done got %0d want 0", done_cnt); end
        vectors++; if (rsp_cyc !== TO) begin miscompares++; $display("FAIL to_rsp_cycles got %0d want %0d", rsp_cyc, TO); end
        vectors++; if (end_stall !== 1'b0 || stall_cnt !== TO + 2) begin miscompares++; $display("FAIL to_stall got end=%b cnt=%0d want 0/%0d", end_stall, stall_cnt, TO + 2); end
        vectors++; if (load_data_o !== 32'h0) begin miscompares++; $display("FAIL to_load got %h want 0", load_data_o); end
        @(negedge clk);
        vectors++; if ({err_o, stall_o, bus_req_valid} !== 3'b000) begin miscompares++; $display("FAIL to_after got %b want 000", {err_o, stall_o, bus_req_valid}); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        mem_rd_en = 1'b1; funct3 = 3'b010; addr = 32'h30; bus_req_ready = 1'b0;
        @(posedge clk); #1;
        mem_rd_en = 1'b0;
        @(negedge clk);
        vectors++; if (bus_req_valid !== 1'b1) begin miscompares++; $display("FAIL rstmid_inreq got %b want 1", bus_req_valid); end
        #1 rst = 1'b0;
        #1;
        vectors++; if (bus_req_valid !== 1'b0 || stall_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_drop got v=%b s=%b want 0/0", bus_req_valid, stall_o); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            vectors++; if ({bus_req_valid, stall_o} !== 2'b00) begin miscompares++; $display("FAIL rstmid_idle got %b want 00", {bus_req_valid, stall_o}); end
            @(posedge clk); #1;
        end
        run_access(1'b1, 1'b0, 3'b101, 32'h52, 32'h0, 32'hF00D_0000, 0, 0, 1'b0);
        vectors++; if (load_data_o !== 32'h0000_F00D || done_cnt !== 1) begin miscompares++; $display("FAIL rstmid_resume got %h done=%0d want 0000f00d/1", load_data_o, done_cnt); end
    endtask

    task automatic test_random();
        logic [2:0]  kinds [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b000, 3'b001, 3'b010};
        logic [2:0]  f3;
        logic        st;
        logic [31:0] a, wd, rd;
        int k, rdy, rsp;
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 7);
            f3 = kinds[k]; st = (k >= 5);
            a = $urandom & ~(32'(acc_size(f3)) - 32'h1);
            wd = $urandom; rd = $urandom;
            rdy = $urandom_range(0, 3); rsp = $urandom_range(0, 3);
            run_access(!st, st, f3, a, wd, rd, rdy, rsp, 1'b0);
            vectors++; if (finished !== 1'b1 || done_cnt !== 1 || err_cnt !== 0) begin miscompares++; $display("FAIL rnd%0d_done got fin=%b d=%0d e=%0d", i, finished, done_cnt, err_cnt); end
            vectors++; if (obs_addr !== {a[31:2], 2'b00} || obs_we !== st) begin miscompares++; $display("FAIL rnd%0d_req got a=%h we=%b want %h/%b", i, obs_addr, obs_we, {a[31:2], 2'b00}, st); end
            vectors++; if (obs_be !== ref_be(st, f3, a[1:0])) begin miscompares++; $display("FAIL rnd%0d_be got %b want %b", i, obs_be, ref_be(st, f3, a[1:0])); end
            if (st) begin
                vectors++; if (obs_wdata !== ref_lane(f3, wd)) begin miscompares++; $display("FAIL rnd%0d_wdata got %h want %h", i, obs_wdata, ref_lane(f3, wd)); end
            end
            vectors++; if (load_data_o !== (st ? 32'h0 : ref_load(f3, a[1:0], rd))) begin miscompares++; $display("FAIL rnd%0d_load got %h want %h", i, load_data_o, st ? 32'h0 : ref_load(f3, a[1:0], rd)); end
            vectors++; if (stall_cnt !== rdy + rsp + 3 || end_stall !== 1'b0) begin miscompares++; $display("FAIL rnd%0d_stall got %0d/%b want %0d/0", i, stall_cnt, end_stall, rdy + rsp + 3); end
        end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_loads();
        test_store_half();
        test_misalign();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
